// File: rtl/pattern_sched_if.sv
// Requester-side handshake bundle: per-channel valid/bit from the lanes, one-hot ready back.
// master = serial front-end lanes, slave = the shared detection engine.
interface pattern_sched_if #(
   parameter int N = 4
);
   logic [N-1:0] in_valid;
   logic [N-1:0] in_bit;
   logic [N-1:0] in_ready;

   modport master (output in_valid, output in_bit, input in_ready);
   modport slave  (input in_valid, input in_bit, output in_ready);
endinterface

// File: rtl/pattern_sched.sv
// Shared "01" Moore detector time-multiplexed over N lanes by a round-robin grant; state and hit are
// registered at the consume edge, ready is combinational. Optional per-lane flush under PATSCHED_FLUSH_EN.
module pattern_sched #(
   parameter  int N     = 4,
   parameter  int CNT_W = 8,
   localparam int CW    = $clog2(N)
) (
   input  logic               clk,
   input  logic               reset,
   pattern_sched_if.slave     rq,
   output logic [N-1:0]       match_o,
   output logic               hit_valid_o,
   output logic [CW-1:0]      hit_chan_o,
   output logic [N*CNT_W-1:0] cnt_flat_o,
   input  logic               cnt_clear_i
`ifdef PATSCHED_FLUSH_EN
   ,
   input  logic [N-1:0]       flush_i
`endif
);

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10
   } state_e;

   state_e           st_q [N];
   logic [CNT_W-1:0] cnt_q [N];
   logic [CW-1:0]    ptr_q;
   logic             hit_vld_q;
   logic [CW-1:0]    hit_chan_q;

   logic [N-1:0]     grant_d;
   logic [CW-1:0]    gidx_d;
   logic             gvld_d;
   state_e           nxt_d;
   logic             take_d;
   logic             hit_d;
   logic [N-1:0]     flush_w;

`ifdef PATSCHED_FLUSH_EN
   assign flush_w = flush_i;
`else
   assign flush_w = '0;
`endif

   function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= N) s = s - N;
      return CW'(s);
   endfunction

   // Search starts just past the last granted lane, so it gets lowest priority next time.
   always_comb begin
      grant_d = '0;
      gidx_d  = ptr_q;
      gvld_d  = 1'b0;
      for (int k = 1; k <= N; k++) begin
         if (!gvld_d && rq.in_valid[wrap_idx(ptr_q, k)]) begin
            gvld_d                     = 1'b1;
            gidx_d                     = wrap_idx(ptr_q, k);
            grant_d[wrap_idx(ptr_q, k)] = 1'b1;
         end
      end
      if (reset) begin
         grant_d = '0;
         gvld_d  = 1'b0;
      end
   end

   assign rq.in_ready = grant_d;

   always_comb begin
      nxt_d = S0;
      case (st_q[gidx_d])
         S0:      nxt_d = rq.in_bit[gidx_d] ? S0 : S1;
         S1:      nxt_d = rq.in_bit[gidx_d] ? S2 : S1;
         S2:      nxt_d = rq.in_bit[gidx_d] ? S0 : S1;
         default: nxt_d = S0;
      endcase
   end

   // A flushed lane still handshakes, but its bit is discarded.
   assign take_d = gvld_d && !flush_w[gidx_d];
   assign hit_d  = take_d && (st_q[gidx_d] == S1) && rq.in_bit[gidx_d];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q      <= CW'(N - 1);
         hit_vld_q  <= 1'b0;
         hit_chan_q <= '0;
         for (int i = 0; i < N; i++) begin
            st_q[i]  <= S0;
            cnt_q[i] <= '0;
         end
      end else begin
         if (gvld_d) ptr_q <= gidx_d;
         hit_vld_q <= hit_d;
         if (hit_d) hit_chan_q <= gidx_d;
         for (int i = 0; i < N; i++) begin
            if (flush_w[i])
               st_q[i] <= S0;
            else if (take_d && gidx_d == CW'(i))
               st_q[i] <= nxt_d;
            // Clear beats a same-cycle increment; the count sticks at all-ones.
            if (cnt_clear_i)
               cnt_q[i] <= '0;
            else if (hit_d && gidx_d == CW'(i) && cnt_q[i] != {CNT_W{1'b1}})
               cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_out
      assign match_o[g]                   = (st_q[g] == S2);
      assign cnt_flat_o[g*CNT_W +: CNT_W] = cnt_q[g];
   end

   assign hit_valid_o = hit_vld_q;
   assign hit_chan_o  = hit_chan_q;

endmodule

// File: doc/pattern_sched.md
Name: pattern_sched

Overview:
- Shares one "01" Moore sequence-detection engine among N serial bit-stream requesters.
- A round-robin arbiter grants one requester per cycle. The engine reads that channel's stored 2-bit state, computes the next state and writes it back.
- Provides a per-channel Moore match level, a single-cycle hit event with the channel ID, and per-channel saturating match counters.
- Sits between the serial front-end lanes and the status/interrupt logic.

Parameters:
- N, 4, number of requester channels (N >= 2).
- CNT_W, 8, width of each per-channel match counter.
- CW, $clog2(N), channel index width (derived; do not override).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  N  channel i has a bit pending.
- in_bit  in  N  serial bit for channel i; held stable while in_valid[i] && !in_ready[i].
- in_ready  out  N  one-hot grant; the bit is consumed when in_valid[i] && in_ready[i].
- match  out  N  Moore output: channel i's stored state == S2.
- hit_valid  out  1  pulse; a channel entered S2 on the previous edge.
- hit_chan  out  CW  channel that caused hit_valid.
- cnt_flat  out  N*CNT_W  per-channel match counters; channel i occupies [i*CNT_W +: CNT_W].
- cnt_clear  in  1  synchronous clear of all counters.
- flush  in  N  per-channel synchronous state flush (present only with PATSCHED_FLUSH_EN).

Behaviour:
- Reset (async): all channel states = S0; rr pointer = N-1 (so channel 0 has priority first); match = 0; hit_valid = 0; hit_chan = 0; all counters = 0.
- Per-channel FSM, encoding S0 = 2'b00, S1 = 2'b01, S2 = 2'b10:
  - S0: bit=1 -> S0; bit=0 -> S1.
  - S1: bit=1 -> S2; bit=0 -> S1.
  - S2: bit=1 -> S0; bit=0 -> S1.
  - Illegal encoding 2'b11 -> S0 on the next consumption.
- Arbiter:
  - Combinational in_ready: grant the first asserted in_valid searching from (ptr+1) mod N upward with wrap.
  - At most one bit of in_ready is set; in_ready = 0 when no in_valid is set.
  - in_ready never asserts for a channel whose in_valid = 0.
  - ptr updates to the granted index only on a consume cycle; otherwise it holds.
- Latency:
  - Bit consumed at edge T -> that channel's state updates at T.
  - match[i] reflects the new state immediately after T (registered state, Moore).
  - hit_valid/hit_chan are registered at T when the transition enters S2 from S1; hit_valid is high for exactly one cycle unless another channel hits the next cycle.
- Ungranted channels keep their state; only the granted channel's state is written.
- Counter:
  - On a transition into S2, cnt[i] increments; it saturates at 2^CNT_W-1 with no wrap.
  - cnt_clear wins over a simultaneous increment, and the counter reads 0 afterwards.
- Fairness: with all N channels continuously valid, each is granted exactly once every N cycles in order 0,1,...,N-1,0,...
- Reset mid-stream: all states and counters clear immediately. The requester retains its pending bit and re-presents it; it is not consumed while reset is high because in_ready = 0 during reset.

Optional Feature:
- Macro: PATSCHED_FLUSH_EN.
- Defined: the flush[N] port exists. flush[i] forces channel i's state to S0 at the next edge, overriding a same-cycle consumption on that channel. That consumption still counts as a handshake (the bit is dropped) and produces no hit or count. The arbiter and ptr are unaffected.
- Undefined: the flush port is absent; channel state changes only via consumption or reset.

Test Plan:
- After reset, ch0 sends 0 then 1 (ch0 only valid) -> in_ready[0] = 1 on each, match[0] = 1 after the second edge, hit_valid = 1 with hit_chan = 0 for one cycle, cnt0 = 1.
- All 4 channels continuously valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each channel consumes exactly 2 bits.
- ch2 stream 0,1,1,0,1 interleaved with ch1 valid -> match[2] sequence (sampled after ch2 edges) 0,1,0,0,1; ch1 state unaffected; cnt2 = 2.
- Force cnt0 to 255 via repeated 0,1 pairs (CNT_W = 8), then one more pair -> cnt0 stays 255; cnt_clear on the same cycle as the next hit -> cnt0 = 0.
- Assert reset while ch3 is in S1 with in_valid[3] = 1 -> in_ready = 0 during reset, match = 0, cnt all 0; after release, ch3 bit 1 -> state S0, no hit.
- PATSCHED_FLUSH_EN: ch1 in S1, flush[1] with ch1 bit 1 consumed the same cycle -> state S0, hit_valid = 0, cnt1 unchanged.
